// File: rtl/phased_burst_generator_if.sv
// Control/configuration/output bundle for the phased burst generator.
// The master side (steering logic) drives configuration and start/stop;
// the slave side (generator) returns status and the transducer outputs.
interface phased_burst_generator_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 10,
  parameter int PH_W    = CNT_W + 1,
  parameter int BURST_W = 8
);
  logic [CNT_W-1:0]       half_period;
  logic [NUM_CH*PH_W-1:0] phase_offset;
  logic [NUM_CH-1:0]      ch_enable;
  logic [BURST_W-1:0]     burst_len;
  logic                   start;
  logic                   stop;
  logic                   busy;
  logic                   done;
  logic                   sync;
  logic [NUM_CH-1:0]      out;

  modport master (
    output half_period, phase_offset, ch_enable, burst_len, start, stop,
    input  busy, done, sync, out
  );

  modport slave (
    input  half_period, phase_offset, ch_enable, burst_len, start, stop,
    output busy, done, sync, out
  );
endinterface

// File: rtl/phased_burst_generator.sv
// Phase-steerable multi-channel square-wave burst generator.
// One master counter (0..2H-1) is shared by all channels; each channel
// is a phase-shifted view of it, gated by a per-channel armed flag so
// every channel emits exactly N whole periods.
//
// state | meaning
// IDLE  | waiting for start; outputs low
// RUN   | master periods being counted; channels arm at their phase
// TAIL  | N master periods done; channels disarm at their phase
module phased_burst_generator #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 10,
  parameter int PH_W    = CNT_W + 1,
  parameter int BURST_W = 8,
  parameter int H_MIN   = 2
) (
  input  logic clk,
  input  logic rst_n,
  phased_burst_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TAIL = 2'd2} state_t;

  state_t             state;
  logic [PH_W-1:0]    mcnt;
  logic [PH_W-1:0]    last_r;
  logic [PH_W-1:0]    pmax_r;
  logic [CNT_W-1:0]   h_r;
  logic [PH_W-1:0]    ph_r [NUM_CH];
  logic [NUM_CH-1:0]  en_r;
  logic [NUM_CH-1:0]  armed;
  logic [BURST_W-1:0] n_r;
  logic [BURST_W-1:0] pcnt;
  logic               busy_r;
  logic               done_r;
  logic               sync_r;
  logic [NUM_CH-1:0]  out_r;

  logic [CNT_W-1:0]   h_cl;
  logic [PH_W-1:0]    last_cl;
  logic [PH_W-1:0]    pmax_cl;
  logic [PH_W-1:0]    ph_cl [NUM_CH];

  // Clamp the incoming configuration so it is ready to latch on start
  always_comb begin
    h_cl    = (bus.half_period < CNT_W'(H_MIN)) ? CNT_W'(H_MIN) : bus.half_period;
    last_cl = PH_W'({h_cl, 1'b0}) - PH_W'(1);
    pmax_cl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ph_cl[i] = bus.phase_offset[i*PH_W +: PH_W];
      if (ph_cl[i] > last_cl) ph_cl[i] = last_cl;
      if (bus.ch_enable[i] && (ph_cl[i] > pmax_cl)) pmax_cl = ph_cl[i];
    end
  end

  logic [NUM_CH-1:0] armed_nxt;
  logic [NUM_CH-1:0] out_nxt;
  logic [PH_W:0]     d;

  // Per-channel arm/disarm and phase-shifted half-period compare
  always_comb begin
    armed_nxt = armed;
    out_nxt   = '0;
    d         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state == RUN) && en_r[i] && (mcnt == ph_r[i])) armed_nxt[i] = 1'b1;
      if ((state == TAIL) && (mcnt == ph_r[i]))           armed_nxt[i] = 1'b0;
      if (mcnt >= ph_r[i])
        d = {1'b0, mcnt} - {1'b0, ph_r[i]};
      else
        d = {1'b0, mcnt} + {1'b0, last_r} + (PH_W+1)'(1) - {1'b0, ph_r[i]};
      out_nxt[i] = armed_nxt[i] && (d < (PH_W+1)'(h_r));
    end
  end

  // Sequencer, master/period counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcnt   <= '0;
      last_r <= '0;
      pmax_r <= '0;
      h_r    <= '0;
      en_r   <= '0;
      armed  <= '0;
      n_r    <= '0;
      pcnt   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sync_r <= 1'b0;
      out_r  <= '0;
      for (int i = 0; i < NUM_CH; i++) ph_r[i] <= '0;
    end else begin
      done_r <= 1'b0;
      sync_r <= 1'b0;
      case (state)
        IDLE: begin
          out_r <= '0;
          armed <= '0;
          // stop has priority over a simultaneous start
          if (bus.start && !bus.stop) begin
            state  <= RUN;
            busy_r <= 1'b1;
            mcnt   <= '0;
            pcnt   <= '0;
            h_r    <= h_cl;
            last_r <= last_cl;
            pmax_r <= pmax_cl;
            en_r   <= bus.ch_enable;
            n_r    <= bus.burst_len;
            for (int i = 0; i < NUM_CH; i++) ph_r[i] <= ph_cl[i];
          end
        end
        RUN, TAIL: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            out_r  <= '0;
            armed  <= '0;
            mcnt   <= '0;
          end else begin
            mcnt  <= (mcnt == last_r) ? '0 : mcnt + PH_W'(1);
            armed <= armed_nxt;
            out_r <= out_nxt;
            if (state == RUN) begin
              sync_r <= (mcnt == '0);
              if (mcnt == last_r) begin
                if (pcnt != '1) pcnt <= pcnt + BURST_W'(1);
                if ((n_r != '0) && (pcnt == n_r - BURST_W'(1))) state <= TAIL;
              end
            end else if (mcnt == pmax_r) begin
              // the latest-phase enabled channel has just disarmed
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sync = sync_r;
  assign bus.out  = out_r;

endmodule

// File: tb/tb_phased_burst_generator.sv
// Scoreboard bench: stimulus pushes expected output-change events
// (absolute cycle + {out,busy,done,sync}); a monitor pops and compares
// whenever the DUT outputs change.
module tb_phased_burst_generator;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 10;
  localparam int PH_W    = 11;
  localparam int BURST_W = 8;
  localparam int BIG     = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  phased_burst_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PH_W(PH_W), .BURST_W(BURST_W)) bus ();

  phased_burst_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PH_W(PH_W), .BURST_W(BURST_W), .H_MIN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         passed = 0;
  logic       mon_en = 1'b0;
  logic [6:0] mon_prev = '0;
  logic [6:0] gen_prev = '0;

  int         cfg_h, cfg_n;
  int         cfg_p[4];
  logic [3:0] cfg_en;
  int         m_he, m_d;
  int         m_pe[4];

  // Expected {out[3:0], busy, done, sync} at cycle rel after start (closed-form timing)
  function automatic logic [6:0] exp_vec(input int rel, input int kill);
    logic [3:0] o;
    logic b, dn, s;
    int j;
    o = '0; b = 1'b0; dn = 1'b0; s = 1'b0;
    if (rel < kill) begin
      b  = (rel >= 1) && ((cfg_n == 0) || (rel < m_d));
      dn = (cfg_n != 0) && (rel == m_d);
      j  = rel - 2;
      s  = (j >= 0) && ((j % (2*m_he)) == 0) && ((cfg_n == 0) || ((j / (2*m_he)) < cfg_n));
      for (int i = 0; i < 4; i++) begin
        j = rel - 2 - m_pe[i];
        o[i] = cfg_en[i] && (j >= 0) && ((j % (2*m_he)) < m_he) &&
               ((cfg_n == 0) || ((j / (2*m_he)) < cfg_n));
      end
    end
    return {o, b, dn, s};
  endfunction

  task automatic push_burst(input int t0, input int rel_from, input int rel_to, input int kill);
    int pmax, last;
    logic [6:0] v;
    m_he = (cfg_h < 2) ? 2 : cfg_h;
    pmax = 0;
    for (int i = 0; i < 4; i++) begin
      m_pe[i] = (cfg_p[i] > 2*m_he - 1) ? 2*m_he - 1 : cfg_p[i];
      if (cfg_en[i] && (m_pe[i] > pmax)) pmax = m_pe[i];
    end
    m_d  = 2 + pmax + cfg_n * 2 * m_he;
    last = (rel_to >= 0) ? rel_to : ((cfg_n > 0) ? m_d + 1 : kill);
    if (last > kill) last = kill;
    for (int rel = rel_from; rel <= last; rel++) begin
      v = exp_vec(rel, kill);
      if (v !== gen_prev) begin
        exp_q.push_back('{t0 + rel, v});
        gen_prev = v;
      end
    end
  endtask

  task automatic set_cfg(input int h, input int n, input int p0, input int p1,
                         input int p2, input int p3, input logic [3:0] en);
    cfg_h = h; cfg_n = n; cfg_en = en;
    cfg_p[0] = p0; cfg_p[1] = p1; cfg_p[2] = p2; cfg_p[3] = p3;
    bus.half_period = CNT_W'(h);
    bus.burst_len   = BURST_W'(n);
    bus.ch_enable   = en;
    for (int i = 0; i < 4; i++) bus.phase_offset[i*PH_W +: PH_W] = PH_W'(cfg_p[i]);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL %s: %0d expected events never seen, next due cycle %0d",
                  name, exp_q.size(), exp_q[0].cyc);
  endtask

  // Monitor: every output change must match the next expected event
  always @(negedge clk) begin
    logic [6:0] v;
    ev_t e;
    v = {bus.out, bus.busy, bus.done, bus.sync};
    if (mon_en && (v !== mon_prev)) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b", cyc, v, mon_prev);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc == cyc) && (e.v === v)) passed++;
        else $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d", v, cyc, e.v, e.cyc);
      end
    end
    mon_prev = v;
  end

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 4'h0);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out, bus.busy, bus.done, bus.sync} == 7'b0) passed++;
    else $display("FAIL reset_state: got %b required 0000000", {bus.out, bus.busy, bus.done, bus.sync});
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 40 kHz, three periods, staggered phases
    set_cfg(337, 3, 0, 169, 337, 673, 4'hF);
    t0 = cyc;
    push_burst(t0, 0, -1, BIG);
    pulse_start();
    wait_to(t0 + 2697 + 5);
    check_drained("s1_burst");

    // 2: continuous, stopped at cycle 40
    set_cfg(4, 0, 0, 0, 0, 0, 4'hF);
    t0 = cyc;
    push_burst(t0, 0, -1, 41);
    pulse_start();
    wait_to(t0 + 40);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_to(t0 + 60);
    check_drained("s2_stop");

    // 3: clamping; start held high so a second burst begins at cycle D
    set_cfg(1, 2, 7, 0, 0, 0, 4'b0001);
    t0 = cyc;
    push_burst(t0, 0, 13, BIG);
    push_burst(t0 + 13, 1, -1, BIG);
    bus.start = 1'b1;
    wait_to(t0 + 14);
    bus.start = 1'b0;
    wait_to(t0 + 32);
    check_drained("s3_clamp_backtoback");

    // 4: start+stop ignored, then busy-time start/config changes ignored
    set_cfg(5, 2, 0, 3, 9, 12, 4'hF);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (5) @(negedge clk);
    t0 = cyc;
    push_burst(t0, 0, -1, BIG);
    pulse_start();
    wait_to(t0 + 10);
    bus.half_period = CNT_W'(20);
    pulse_start();
    wait_to(t0 + 20);
    bus.phase_offset = '0;
    bus.ch_enable    = '0;
    wait_to(t0 + 40);
    check_drained("s4_ignored_inputs");

    // 5: async reset mid-burst, then a fresh burst
    set_cfg(337, 3, 0, 169, 337, 673, 4'hF);
    t0 = cyc;
    push_burst(t0, 0, -1, 100);
    pulse_start();
    wait_to(t0 + 99);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ((bus.out == 4'h0) && (bus.busy == 1'b0)) passed++;
    else $display("FAIL reset_midburst: got out=%b busy=%b required out=0000 busy=0", bus.out, bus.busy);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_drained("s5_reset");
    t0 = cyc;
    push_burst(t0, 0, -1, BIG);
    pulse_start();
    wait_to(t0 + 2697 + 5);
    check_drained("s5_restart");

    // 6: no channels enabled
    set_cfg(5, 2, 0, 0, 0, 0, 4'h0);
    t0 = cyc;
    push_burst(t0, 0, -1, BIG);
    pulse_start();
    wait_to(t0 + 30);
    check_drained("s6_no_channels");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
